harq_send_ctrl: RTL
===================

HARQ_SEND_CTRL -- requirements
Module: harq_send_ctrl

Interface
REQ-001 The block SHALL have port i_core_clk, input, 1 bit: clock; all state changes on its rising edge.
REQ-002 The block SHALL have port i_rx_rstn, input, 1 bit: reset, asynchronous, active-low.
REQ-003 The block SHALL have ports i_ping_request and i_pong_request, input, 1 bit each: a buffer is ready to send; held high until the matching comp pulse.
REQ-004 The block SHALL have ports i_ping_add_amount and i_pong_add_amount, input, 16 bits each: soft values to send.
REQ-005 The block SHALL have ports i_ping_user_index and i_pong_user_index, input, 4 bits each: user tag.
REQ-006 The block SHALL have ports i_ping_rd_data and i_pong_rd_data, input, 160 bits each: buffer read data, 16 signed 10-bit lanes, valid 1 cycle after address.
REQ-007 The block SHALL have port o_rd_address, output, 11 bits: shared read address to both buffers.
REQ-008 The block SHALL have ports o_ping_busy and o_pong_busy, output, 1 bit each: buffer owned by this block.
REQ-009 The block SHALL have ports o_ping_comp and o_pong_comp, output, 1 bit each: one-cycle completion pulses.
REQ-010 The block SHALL have output ports o_harq_valid (1 bit), o_harq_data (128 bits, 16 signed 8-bit lanes), o_harq_addr (11 bits, word index), o_harq_user_index (4 bits), o_harq_last (1 bit) and o_harq_buf_sel (1 bit, 0=ping): the HARQ write stream.

Function
REQ-011 The FSM SHALL have states IDLE, SEL, READ, DRAIN, DONE; encoding free.
REQ-012 IDLE->SEL SHALL occur when either request is high, except in the first cycle after DONE, when requests are ignored.
REQ-013 SEL SHALL grant ping if only ping is requesting and pong if only pong is requesting; if both, it SHALL grant the buffer not served last; last-served resets to pong.
REQ-014 In SEL the block SHALL latch sel, user index and words = ceil(amount/16), clamped to 2048, and SHALL set the granted busy high.
REQ-015 SEL SHALL go to DONE if words==0, else to READ.
REQ-016 READ SHALL issue address 0..words-1, one per cycle, on o_rd_address, then go to DRAIN.
REQ-017 DRAIN SHALL last 2 cycles, then go to DONE.
REQ-018 For each address k, o_harq_valid SHALL be high 2 cycles after k is issued, with o_harq_addr=k, o_harq_data from the selected buffer, and o_harq_last=1 for k==words-1 only.
REQ-019 o_harq_user_index and o_harq_buf_sel SHALL hold the latched grant values.
REQ-020 In DONE the block SHALL pulse the granted comp for one cycle, clear busy in the same cycle, toggle last-served, and return to IDLE.
REQ-021 o_rd_address SHALL hold its last value outside READ; no reads are issued to the ungranted buffer.
REQ-022 A request deasserted mid-transfer SHALL be ignored; the transfer completes in full.

Reset
REQ-023 On i_rx_rstn low, the FSM SHALL return to IDLE immediately, mid-transfer included, with no comp pulse.
REQ-024 On reset, all outputs SHALL be 0 and last-served SHALL be pong.
REQ-025 The output pipeline SHALL be flushed on reset, so no valid is emitted after reset release until a new grant.

Configuration
REQ-026 With HARQ_SEND_SAT_EN defined, each 10-bit lane SHALL be saturated to the range -128..127 in 8 bits.
REQ-027 Without HARQ_SEND_SAT_EN, each lane SHALL be truncated to its low 8 bits.

Verification
REQ-028 The bench SHALL cover: ping request, amount=40 -> busy set, 3 valids at addr 0,1,2, last on addr 2, one ping_comp pulse 2 cycles after the last address, busy cleared.
REQ-029 The bench SHALL cover: ping and pong requested in the same cycle after reset -> ping served first, then pong; pong_comp follows ping_comp.
REQ-030 The bench SHALL cover: amount=0 -> no valid, comp pulse 2 cycles after grant.
REQ-031 The bench SHALL cover: amount=40000 -> exactly 2048 words, last on addr 2047.
REQ-032 The bench SHALL cover: lane value 10'h1F4 (+500) -> 8'h7F with macro, 8'hF4 without; 10'h200 (-512) -> 8'h80 with, 8'h00 without.
REQ-033 The bench SHALL cover: reset asserted at word 5 of 100 -> outputs 0 at once, no comp; the next request starts at addr 0.

Source files
------------

// File: rtl/harq_send_ctrl_if.sv
// harq_send_ctrl_if
// HARQ write stream that harq_send_ctrl produces.
// Signals:
//   o_harq_valid      - one beat of 16 lanes is present this cycle
//   o_harq_data       - 16 signed 8-bit lanes, lane 0 in bits [7:0]
//   o_harq_addr       - word index inside the transfer
//   o_harq_user_index - user tag of the granted buffer
//   o_harq_last       - final beat of the transfer
//   o_harq_buf_sel    - source buffer, 0 = ping, 1 = pong
// Modports: master drives the stream, slave consumes it.
interface harq_send_ctrl_if;
  logic         o_harq_valid;
  logic [127:0] o_harq_data;
  logic [10:0]  o_harq_addr;
  logic [3:0]   o_harq_user_index;
  logic         o_harq_last;
  logic         o_harq_buf_sel;

  modport master (
    output o_harq_valid, o_harq_data, o_harq_addr,
           o_harq_user_index, o_harq_last, o_harq_buf_sel
  );

  modport slave (
    input  o_harq_valid, o_harq_data, o_harq_addr,
           o_harq_user_index, o_harq_last, o_harq_buf_sel
  );
endinterface

// File: rtl/harq_send_ctrl.sv
// harq_send_ctrl
// Arbitrates between the ping and pong soft-value buffers. It reads the
// granted buffer word by word, narrows every 10-bit lane to 8 bits and
// forwards the words on the HARQ write stream. Completion is reported
// with a one-cycle comp pulse.
//
// Build option: HARQ_SEND_SAT_EN
//   defined   - each lane saturates to -128..127
//   undefined - each lane keeps its low 8 bits
//
// Ports:
//   i_core_clk                 clock, rising edge
//   i_rx_rstn                  asynchronous active-low reset
//   i_ping/pong_request        buffer ready, held until its comp pulse
//   i_ping/pong_add_amount     number of soft values to send
//   i_ping/pong_user_index     user tag
//   i_ping/pong_rd_data        buffer read data, 1 cycle after address
//   o_rd_address               read address shared by both buffers
//   o_ping/pong_busy           buffer owned by this block
//   o_ping/pong_comp           one-cycle completion pulse
//   harq                       HARQ write stream (master modport)
//
// Timing: o_rd_address shows word k one cycle after the READ cycle that
// issues it; read data follows one cycle later; the beat for word k
// appears two cycles after address k is shown. comp and the busy clear
// are visible during DONE, together with the last beat.
//
// state | meaning
// IDLE  | waiting for a request (ignored for one cycle after DONE)
// SEL   | grant latched, busy shown, choose READ or DONE
// READ  | issue one word address per cycle
// DRAIN | two cycles while the read pipeline empties
// DONE  | comp pulse, last-served toggles
module harq_send_ctrl (
  input  logic            i_core_clk,
  input  logic            i_rx_rstn,
  input  logic            i_ping_request,
  input  logic            i_pong_request,
  input  logic [15:0]     i_ping_add_amount,
  input  logic [15:0]     i_pong_add_amount,
  input  logic [3:0]      i_ping_user_index,
  input  logic [3:0]      i_pong_user_index,
  input  logic [159:0]    i_ping_rd_data,
  input  logic [159:0]    i_pong_rd_data,
  output logic [10:0]     o_rd_address,
  output logic            o_ping_busy,
  output logic            o_pong_busy,
  output logic            o_ping_comp,
  output logic            o_pong_comp,
  harq_send_ctrl_if.master harq
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SEL   = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]   r_state;
  logic [2:0]   w_next;
  logic         r_hold;         // first IDLE cycle after DONE
  logic         r_last_served;  // 1 = pong
  logic         r_sel;
  logic [3:0]   r_user;
  logic [10:0]  r_words_m1;
  logic         r_words_zero;
  logic [10:0]  r_idx;
  logic         r_drain;
  logic [10:0]  r_rd_addr;
  logic         r_a_vld;
  logic         r_a_last;
  logic         r_b_vld;
  logic         r_b_last;
  logic [10:0]  r_b_addr;
  logic         r_out_vld;
  logic         r_out_last;
  logic [10:0]  r_out_addr;
  logic [127:0] r_out_data;
  logic         r_ping_busy;
  logic         r_pong_busy;
  logic         r_ping_comp;
  logic         r_pong_comp;

  logic         w_grant_pong;
  logic         w_grant;
  logic [15:0]  w_amount;
  logic [11:0]  w_wm1;
  logic [159:0] w_rd_data;
  logic [127:0] w_lanes;

  // Both requesting: serve the buffer that was not served last.
  assign w_grant_pong = i_pong_request & (~i_ping_request | ~r_last_served);
  assign w_grant      = (r_state == S_IDLE) && (w_next == S_SEL);
  assign w_amount     = w_grant_pong ? i_pong_add_amount : i_ping_add_amount;
  // ceil(a/16) - 1 == floor((a-1)/16) for a >= 1; a == 0 is flagged apart.
  assign w_wm1        = 12'((w_amount - 16'd1) >> 4);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (!r_hold && (i_ping_request || i_pong_request)) w_next = S_SEL;
      S_SEL:   w_next = r_words_zero ? S_DONE : S_READ;
      S_READ:  if (r_idx == r_words_m1) w_next = S_DRAIN;
      S_DRAIN: if (r_drain) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      r_state       <= S_IDLE;
      r_hold        <= 1'b0;
      r_last_served <= 1'b1;
      r_sel         <= 1'b0;
      r_user        <= '0;
      r_words_m1    <= '0;
      r_words_zero  <= 1'b0;
      r_idx         <= '0;
      r_drain       <= 1'b0;
      r_ping_busy   <= 1'b0;
      r_pong_busy   <= 1'b0;
      r_ping_comp   <= 1'b0;
      r_pong_comp   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_hold  <= (r_state == S_DONE);

      // Grant is captured on the IDLE->SEL edge so it is stable for all of SEL.
      if (w_grant) begin
        r_sel        <= w_grant_pong;
        r_user       <= w_grant_pong ? i_pong_user_index : i_ping_user_index;
        r_words_m1   <= w_wm1[11] ? 11'h7FF : w_wm1[10:0];
        r_words_zero <= (w_amount == 16'd0);
        r_idx        <= '0;
      end else if (r_state == S_READ && w_next == S_READ) begin
        r_idx <= r_idx + 11'd1;
      end

      r_drain <= (r_state == S_DRAIN) && !r_drain;

      if (w_next == S_DONE) begin
        r_ping_busy <= 1'b0;
        r_pong_busy <= 1'b0;
      end else if (w_grant) begin
        r_ping_busy <= ~w_grant_pong;
        r_pong_busy <= w_grant_pong;
      end

      r_ping_comp <= (w_next == S_DONE) && !r_sel;
      r_pong_comp <= (w_next == S_DONE) && r_sel;

      if (r_state == S_DONE) r_last_served <= ~r_last_served;
    end
  end

  // Read pipeline: address stage, data-return stage, output stage.
  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      r_rd_addr  <= '0;
      r_a_vld    <= 1'b0;
      r_a_last   <= 1'b0;
      r_b_vld    <= 1'b0;
      r_b_last   <= 1'b0;
      r_b_addr   <= '0;
      r_out_vld  <= 1'b0;
      r_out_last <= 1'b0;
      r_out_addr <= '0;
      r_out_data <= '0;
    end else begin
      if (r_state == S_READ) r_rd_addr <= r_idx;
      r_a_vld    <= (r_state == S_READ);
      r_a_last   <= (r_state == S_READ) && (r_idx == r_words_m1);
      r_b_vld    <= r_a_vld;
      r_b_last   <= r_a_last;
      r_b_addr   <= r_rd_addr;
      r_out_vld  <= r_b_vld;
      r_out_last <= r_b_last;
      if (r_b_vld) begin
        r_out_addr <= r_b_addr;
        r_out_data <= w_lanes;
      end
    end
  end

  assign w_rd_data = r_sel ? i_pong_rd_data : i_ping_rd_data;

  always_comb begin
    w_lanes = '0;
    for (int l = 0; l < 16; l++) begin
`ifdef HARQ_SEND_SAT_EN
      // In range when bits [9:7] are all equal; otherwise clip by sign.
      if (w_rd_data[l*10+7 +: 3] == 3'b000 || w_rd_data[l*10+7 +: 3] == 3'b111)
        w_lanes[l*8 +: 8] = w_rd_data[l*10 +: 8];
      else
        w_lanes[l*8 +: 8] = w_rd_data[l*10+9] ? 8'h80 : 8'h7F;
`else
      w_lanes[l*8 +: 8] = w_rd_data[l*10 +: 8];
`endif
    end
  end

`ifndef HARQ_SEND_SAT_EN
  // Truncation drops the two top bits of every lane.
  logic w_unused_msbs;
  always_comb begin
    w_unused_msbs = 1'b0;
    for (int l = 0; l < 16; l++) w_unused_msbs = w_unused_msbs ^ (^w_rd_data[l*10+8 +: 2]);
  end
`endif

  assign o_rd_address           = r_rd_addr;
  assign o_ping_busy            = r_ping_busy;
  assign o_pong_busy            = r_pong_busy;
  assign o_ping_comp            = r_ping_comp;
  assign o_pong_comp            = r_pong_comp;
  assign harq.o_harq_valid      = r_out_vld;
  assign harq.o_harq_data       = r_out_data;
  assign harq.o_harq_addr       = r_out_addr;
  assign harq.o_harq_user_index = r_user;
  assign harq.o_harq_last       = r_out_last;
  assign harq.o_harq_buf_sel    = r_sel;

endmodule
